bus_arbiter_rr_split: RTL
=========================

Name: bus_arbiter_rr_split

Overview:
- Registered bus arbiter for the 2-master / 3-slave serial bus.
- Shares the single serial datapath between M1 and M2, with selectable fixed-priority or round-robin arbitration.
- Owns all split-transaction sequencing for the split-capable slave S3: suspend, hand-over, resume and timeout-abort.
- Drives bgrant/msel into the bus master-side mux, and split_grant to the address decoder.

Parameters:
- RR_MODE, 0: 0 = fixed priority, M1 > M2; 1 = round-robin on simultaneous requests.
- SPLIT_TIMEOUT, 255: maximum cycles a split may stay pending before abort; 0 disables the timeout.
- CNT_WIDTH, 8: width of the split timer; must hold SPLIT_TIMEOUT.

Ports:
- clk  in  1  bus clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- breq1  in  1  M1 bus request; held high for the whole transaction.
- breq2  in  1  M2 bus request.
- sreadysp  in  1  S3 ready; high means the split data is available.
- ssplit  in  1  S3 split indication; sampled only while a master owns the bus.
- bgrant1  out  1  M1 grant.
- bgrant2  out  1  M2 grant.
- msel  out  1  master mux select (0 = M1, 1 = M2).
- msplit1  out  1  M1 is suspended in a split.
- msplit2  out  1  M2 is suspended in a split.
- split_grant  out  1  resumed split transaction in progress.
- split_abort  out  1  one-cycle pulse: pending split aborted by timeout.

Behaviour:
- Reset values:
  - All outputs 0; msel = 0; state = IDLE; timer = 0.
  - last_owner = M2, so M1 wins the first round-robin tie.
- Timing:
  - All outputs are registered.
  - A request sampled at edge n produces its grant after edge n; the grant is visible in cycle n+1.
  - At most one bgrant is high at any time.
- Arbitration rule, applied in IDLE and on release:
  - If only one master requests, that master wins.
  - If both request: RR_MODE = 0 grants M1; RR_MODE = 1 grants the master that is not last_owner.
  - last_owner is updated on every new grant.
  - msel follows the granted master and holds its value while idle.
- States:
  - IDLE:
    - Arbitrate; on a win go to GNT with owner set.
  - GNT:
    - While owner breq = 1: hold the grant.
    - ssplit = 1 (priority over a breq drop in the same cycle):
      - split_owner := owner; msplit[owner] := 1; bgrant[owner] := 0; timer := 0.
      - Go to SPLIT_IDLE.
    - Owner breq = 0:
      - Drop the grant.
      - If the other master is requesting, grant it directly with no idle cycle; otherwise go to IDLE.
  - SPLIT_IDLE:
    - split_owner's breq is ignored.
    - sreadysp = 1 (priority over timeout and the other master's request):
      - Go to RESUME: bgrant[split_owner] := 1, msel := split_owner, split_grant := 1, msplit := 0.
    - Else, other master requesting: grant it and go to SPLIT_GNT.
  - SPLIT_GNT:
    - The other master owns the bus and is never preempted.
    - ssplit is ignored; only one split may be outstanding.
    - On its breq drop: go to RESUME if sreadysp = 1, else to SPLIT_IDLE. The timer keeps running.
  - RESUME:
    - Hold split_grant and the grant while split_owner breq = 1.
    - On drop: clear split_grant and apply the release rule as in GNT.
- Timer:
  - Increments in SPLIT_IDLE and SPLIT_GNT; saturates at SPLIT_TIMEOUT.
  - On reaching SPLIT_TIMEOUT (when SPLIT_TIMEOUT ≠ 0) without a resume:
    - Pulse split_abort and clear msplit.
    - From SPLIT_IDLE go to IDLE. From SPLIT_GNT go to GNT, keeping the current owner.
    - The aborted master re-arbitrates normally.
  - Resume takes precedence over timeout in the same cycle.
- Reset mid-operation: rst high in any state returns every output to its reset value at the next edge, regardless of breq, ssplit or sreadysp.
- Assertions (checked in verification):
  - bgrant1 & bgrant2 never both high.
  - split_grant implies the split_owner grant is high.
  - msplitX implies bgrantX is low.

Test Plan:
- Priority, RR_MODE = 0:
  - Stimulus: breq1 = breq2 = 1 at cycle 0.
  - Required: bgrant1 = 1 in cycle 1, msel = 0. After breq1 drops in cycle 5, bgrant2 = 1 in cycle 6 and msel = 1.
- Round-robin, RR_MODE = 1, both masters requesting continuously with 3-cycle transactions:
  - Required: grants alternate M1, M2, M1, M2; never two consecutive grants to the same master.
- Split with hand-over:
  - Stimulus: M1 granted; ssplit = 1 in cycle 4; breq2 high.
  - Required: msplit1 = 1 and bgrant1 = 0 in cycle 5; bgrant2 = 1 in cycle 6.
  - Then sreadysp = 1 while M2 is still busy; M2 drops breq in cycle 10.
  - Required: in cycle 11, bgrant1 = 1, split_grant = 1, msplit1 = 0.
- Split timeout, SPLIT_TIMEOUT = 8:
  - Stimulus: split by M2; no sreadysp; no other request.
  - Required: split_abort pulses exactly once, 8 cycles after entering SPLIT_IDLE; msplit2 = 0; state returns to IDLE.
- Simultaneous events:
  - Stimulus: ssplit = 1 and owner breq = 0 in the same cycle.
  - Required: the split is taken.
  - Stimulus: sreadysp = 1 on the timeout cycle.
  - Required: resume occurs with no split_abort.
- Reset:
  - Stimulus: rst = 1 during RESUME.
  - Required: next cycle all grants, msplit, split_grant and split_abort = 0, msel = 0; a following breq2 alone is granted 1 cycle after rst deasserts.

Source files
------------

// File: rtl/bus_arbiter_rr_split.sv
// Two-master serial bus arbiter with fixed-priority / round-robin selection
// and split-transaction sequencing (suspend, hand-over, resume, timeout abort) for S3.
module bus_arbiter_rr_split #(
  parameter int unsigned RR_MODE       = 0,
  parameter int unsigned SPLIT_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic breq1,
  input  logic breq2,
  input  logic sreadysp,
  input  logic ssplit,
  output logic bgrant1,
  output logic bgrant2,
  output logic msel,
  output logic msplit1,
  output logic msplit2,
  output logic split_grant,
  output logic split_abort
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT,
    S_SPLIT_IDLE,
    S_SPLIT_GNT,
    S_RESUME
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TO_C = CNT_WIDTH'(SPLIT_TIMEOUT);

  state_t                 r_state, w_state;
  logic                   r_owner, w_owner;
  logic                   r_split_owner, w_split_owner;
  logic                   r_last_owner, w_last_owner;
  logic [CNT_WIDTH-1:0]   r_timer, w_timer;
  logic                   r_bgrant1, w_bgrant1;
  logic                   r_bgrant2, w_bgrant2;
  logic                   r_msel, w_msel;
  logic                   r_msplit1, w_msplit1;
  logic                   r_msplit2, w_msplit2;
  logic                   r_split_grant, w_split_grant;
  logic                   r_split_abort, w_split_abort;

  logic                   w_req_owner;
  logic                   w_req_other;
  logic                   w_req_sother;
  logic                   w_arb_valid;
  logic                   w_arb_win;
  logic [CNT_WIDTH-1:0]   w_timer_inc;
  logic                   w_timeout;
  logic                   w_release;
  logic                   w_resume;

  assign w_req_owner  = r_owner ? breq2 : breq1;
  assign w_req_other  = r_owner ? breq1 : breq2;
  assign w_req_sother = r_split_owner ? breq1 : breq2;

  // Tie goes to M1 in fixed-priority mode, to the non-last owner in round-robin.
  assign w_arb_valid = breq1 | breq2;
  assign w_arb_win   = (breq1 & breq2) ? ((RR_MODE != 0) ? ~r_last_owner : 1'b0) : breq2;

  assign w_timer_inc = (r_timer == TO_C) ? r_timer : r_timer + 1'b1;
  assign w_timeout   = (SPLIT_TIMEOUT != 0) && (w_timer_inc == TO_C);

  always_comb begin
    w_state       = r_state;
    w_owner       = r_owner;
    w_split_owner = r_split_owner;
    w_last_owner  = r_last_owner;
    w_timer       = r_timer;
    w_bgrant1     = r_bgrant1;
    w_bgrant2     = r_bgrant2;
    w_msel        = r_msel;
    w_msplit1     = r_msplit1;
    w_msplit2     = r_msplit2;
    w_split_grant = r_split_grant;
    w_split_abort = 1'b0;
    w_release     = 1'b0;
    w_resume      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_timer = '0;
        if (w_arb_valid) begin
          w_state      = S_GNT;
          w_owner      = w_arb_win;
          w_last_owner = w_arb_win;
          w_msel       = w_arb_win;
          w_bgrant1    = ~w_arb_win;
          w_bgrant2    = w_arb_win;
        end
      end

      S_GNT: begin
        if (ssplit) begin
          w_state       = S_SPLIT_IDLE;
          w_split_owner = r_owner;
          w_msplit1     = ~r_owner;
          w_msplit2     = r_owner;
          w_bgrant1     = 1'b0;
          w_bgrant2     = 1'b0;
          w_timer       = '0;
        end else if (!w_req_owner) begin
          w_release = 1'b1;
        end
      end

      S_SPLIT_IDLE: begin
        w_timer = w_timer_inc;
        if (sreadysp) begin
          w_resume = 1'b1;
        end else if (w_timeout) begin
          w_split_abort = 1'b1;
          w_msplit1     = 1'b0;
          w_msplit2     = 1'b0;
          w_state       = S_IDLE;
          w_timer       = '0;
        end else if (w_req_sother) begin
          w_state      = S_SPLIT_GNT;
          w_owner      = ~r_split_owner;
          w_last_owner = ~r_split_owner;
          w_msel       = ~r_split_owner;
          w_bgrant1    = r_split_owner;
          w_bgrant2    = ~r_split_owner;
        end
      end

      S_SPLIT_GNT: begin
        w_timer = w_timer_inc;
        if (!w_req_owner) begin
          w_bgrant1 = 1'b0;
          w_bgrant2 = 1'b0;
          if (sreadysp) begin
            w_resume = 1'b1;
          end else if (w_timeout) begin
            // Owner left on the same edge the split expired: nobody keeps the bus.
            w_split_abort = 1'b1;
            w_msplit1     = 1'b0;
            w_msplit2     = 1'b0;
            w_state       = S_IDLE;
            w_timer       = '0;
          end else begin
            w_state = S_SPLIT_IDLE;
          end
        end else if (w_timeout) begin
          w_split_abort = 1'b1;
          w_msplit1     = 1'b0;
          w_msplit2     = 1'b0;
          w_state       = S_GNT;
          w_timer       = '0;
        end
      end

      S_RESUME: begin
        if (!w_req_owner) begin
          w_split_grant = 1'b0;
          w_release     = 1'b1;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Release hands the bus straight to a waiting master, otherwise goes idle.
    if (w_release) begin
      if (w_req_other) begin
        w_state      = S_GNT;
        w_owner      = ~r_owner;
        w_last_owner = ~r_owner;
        w_msel       = ~r_owner;
        w_bgrant1    = r_owner;
        w_bgrant2    = ~r_owner;
      end else begin
        w_state   = S_IDLE;
        w_bgrant1 = 1'b0;
        w_bgrant2 = 1'b0;
      end
    end

    if (w_resume) begin
      w_state       = S_RESUME;
      w_owner       = r_split_owner;
      w_last_owner  = r_split_owner;
      w_msel        = r_split_owner;
      w_bgrant1     = ~r_split_owner;
      w_bgrant2     = r_split_owner;
      w_split_grant = 1'b1;
      w_msplit1     = 1'b0;
      w_msplit2     = 1'b0;
      w_timer       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_split_owner <= 1'b0;
      r_last_owner  <= 1'b1;
      r_timer       <= '0;
      r_bgrant1     <= 1'b0;
      r_bgrant2     <= 1'b0;
      r_msel        <= 1'b0;
      r_msplit1     <= 1'b0;
      r_msplit2     <= 1'b0;
      r_split_grant <= 1'b0;
      r_split_abort <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_owner       <= w_owner;
      r_split_owner <= w_split_owner;
      r_last_owner  <= w_last_owner;
      r_timer       <= w_timer;
      r_bgrant1     <= w_bgrant1;
      r_bgrant2     <= w_bgrant2;
      r_msel        <= w_msel;
      r_msplit1     <= w_msplit1;
      r_msplit2     <= w_msplit2;
      r_split_grant <= w_split_grant;
      r_split_abort <= w_split_abort;
    end
  end

  assign bgrant1     = r_bgrant1;
  assign bgrant2     = r_bgrant2;
  assign msel        = r_msel;
  assign msplit1     = r_msplit1;
  assign msplit2     = r_msplit2;
  assign split_grant = r_split_grant;
  assign split_abort = r_split_abort;

endmodule
